// File: rtl/approx_wallace_mac_sequencer.sv
// rtl/approx_wallace_mac_sequencer.sv - dot-product sequencer for the shared approximate 8x8 multiplier
module approx_wallace_mac_sequencer #(
  parameter int N_MAX   = 8,
  parameter int LEN_W   = 4,
  parameter int ACC_W   = 19,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             in_ready,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic             ovf
);

  localparam int               LAT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [LEN_W-1:0] N_MAX_L  = LEN_W'(N_MAX);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] rem;
  logic [LAT_W-1:0] lat;
  logic [ACC_W:0]   acc_sum;

  // One extra bit captures the carry-out that feeds the sticky overflow flag.
  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(mul_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      lat   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            if (len != '0) begin
              rem   <= (len > N_MAX_L) ? N_MAX_L : len;
              state <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            acc   <= '0;
            ovf   <= 1'b0;
            state <= IDLE;
          end else if (in_valid) begin
            mul_a <= in_a;
            mul_b <= in_b;
            lat   <= LAT_INIT;
            state <= MUL;
          end
        end
        MUL: begin
          // Operands stay put here; the product is only trusted once lat reaches zero.
          if (abort) begin
            acc   <= '0;
            ovf   <= 1'b0;
            state <= IDLE;
          end else if (lat != '0) begin
            lat <= lat - 1'b1;
          end else begin
            acc   <= acc_sum[ACC_W-1:0];
            ovf   <= ovf | acc_sum[ACC_W];
            rem   <= rem - 1'b1;
            state <= (rem == LEN_W'(1)) ? DONE : FETCH;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == FETCH);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_data  = acc;

endmodule

// File: tb/tb_approx_wallace_mac_sequencer.sv
// tb/tb_approx_wallace_mac_sequencer.sv - randomized self-checking bench for approx_wallace_mac_sequencer
module tb_approx_wallace_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]      start_v, abort_v, in_valid_v, res_ready_v;
  logic [2:0][3:0] len_v;
  logic [2:0][7:0] in_a_v, in_b_v;

  logic        ir0, ir1, ir2, rv0, rv1, rv2, bz0, bz1, bz2, ov0, ov1, ov2;
  logic [7:0]  ma0, mb0, ma1, mb1, ma2, mb2;
  logic [15:0] mp0, mp1, mp2;
  logic [15:0] p2_d1 = 16'd0;
  logic [15:0] p2_d2 = 16'd0;
  logic [18:0] rd0, rd2;
  logic [16:0] rd1;

  // Ideal multipliers: instances 0/1 see the product one cycle after the operand register,
  // instance 2 sees it three cycles after.
  assign mp0 = 16'(ma0) * 16'(mb0);
  assign mp1 = 16'(ma1) * 16'(mb1);
  always_ff @(posedge clk) begin
    p2_d1 <= 16'(ma2) * 16'(mb2);
    p2_d2 <= p2_d1;
  end
  assign mp2 = p2_d2;

  approx_wallace_mac_sequencer #(.N_MAX(8), .LEN_W(4), .ACC_W(19), .MUL_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .len(len_v[0]), .abort(abort_v[0]),
    .in_valid(in_valid_v[0]), .in_a(in_a_v[0]), .in_b(in_b_v[0]), .in_ready(ir0),
    .mul_a(ma0), .mul_b(mb0), .mul_p(mp0), .res_valid(rv0), .res_data(rd0),
    .res_ready(res_ready_v[0]), .busy(bz0), .ovf(ov0));

  approx_wallace_mac_sequencer #(.N_MAX(8), .LEN_W(4), .ACC_W(17), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .len(len_v[1]), .abort(abort_v[1]),
    .in_valid(in_valid_v[1]), .in_a(in_a_v[1]), .in_b(in_b_v[1]), .in_ready(ir1),
    .mul_a(ma1), .mul_b(mb1), .mul_p(mp1), .res_valid(rv1), .res_data(rd1),
    .res_ready(res_ready_v[1]), .busy(bz1), .ovf(ov1));

  approx_wallace_mac_sequencer #(.N_MAX(8), .LEN_W(4), .ACC_W(19), .MUL_LAT(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .len(len_v[2]), .abort(abort_v[2]),
    .in_valid(in_valid_v[2]), .in_a(in_a_v[2]), .in_b(in_b_v[2]), .in_ready(ir2),
    .mul_a(ma2), .mul_b(mb2), .mul_p(mp2), .res_valid(rv2), .res_data(rd2),
    .res_ready(res_ready_v[2]), .busy(bz2), .ovf(ov2));

  int ncomp = 0;
  int nfail = 0;
  int pa [16];
  int pb [16];

  function automatic logic get_ready(input int i);
    case (i) 0: return ir0; 1: return ir1; default: return ir2; endcase
  endfunction
  function automatic logic get_valid(input int i);
    case (i) 0: return rv0; 1: return rv1; default: return rv2; endcase
  endfunction
  function automatic logic get_busy(input int i);
    case (i) 0: return bz0; 1: return bz1; default: return bz2; endcase
  endfunction
  function automatic logic get_ovf(input int i);
    case (i) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction
  function automatic logic [18:0] get_data(input int i);
    case (i) 0: return rd0; 1: return {2'b00, rd1}; default: return rd2; endcase
  endfunction
  function automatic logic [15:0] get_mul(input int i);
    case (i) 0: return {ma0, mb0}; 1: return {ma1, mb1}; default: return {ma2, mb2}; endcase
  endfunction

  function automatic int acc_w_of(input int i);
    return (i == 1) ? 17 : 19;
  endfunction
  function automatic int lat_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction
  function automatic int terms(input int len);
    return (len > 8) ? 8 : len;
  endfunction
  function automatic int exp_cycles(input int i, input int len);
    return 1 + terms(len) * (lat_of(i) + 1);
  endfunction

  // Reference: plain dot product of the first min(len,8) pairs, wrapped to the accumulator width;
  // overflow is set whenever the true sum reaches 2^ACC_W.
  function automatic void model(input int i, input int len, output logic [18:0] s, output logic o);
    longint t = 0;
    longint m = longint'(1) << acc_w_of(i);
    for (int k = 0; k < terms(len); k++) t += longint'(pa[k]) * longint'(pb[k]);
    s = 19'(t % m);
    o = (t >= m);
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < 16; k++) begin
      pa[k] = int'($urandom_range(0, 255));
      pb[k] = int'($urandom_range(0, 255));
    end
  endfunction

  task automatic run_job(input int i, input int len, input int gap, input int rstall, input int abort_after,
                         output logic [18:0] data, output logic o, output int cyc, output int hs_cnt,
                         output bit seen_ready, output bit got_res);
    int wait_cnt = 0;
    bit hs;
    data = '0; o = 1'b0; cyc = 0; hs_cnt = 0; seen_ready = 0; got_res = 0;
    @(negedge clk);
    start_v[i] = 1'b1;
    len_v[i]   = 4'(len);
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (get_valid(i)) begin
        got_res = 1;
        break;
      end
      if (abort_after >= 0 && hs_cnt == abort_after && get_busy(i) && !get_ready(i)) begin
        abort_v[i] = 1'b1;
        @(posedge clk); #1;
        abort_v[i] = 1'b0;
        return;
      end
      hs = 0;
      if (get_ready(i)) begin
        seen_ready = 1;
        if (hs_cnt < 16 && wait_cnt >= gap) begin
          in_valid_v[i] = 1'b1;
          in_a_v[i] = 8'(pa[hs_cnt]);
          in_b_v[i] = 8'(pb[hs_cnt]);
          hs = 1;
        end else begin
          in_valid_v[i] = 1'b0;
          wait_cnt++;
        end
      end else begin
        in_valid_v[i] = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        hs_cnt++;
        wait_cnt = 0;
      end
    end
    in_valid_v[i] = 1'b0;
    if (!got_res) return;
    data = get_data(i);
    o    = get_ovf(i);
    for (int r = 0; r < rstall; r++) begin
      @(posedge clk); #1;
      ncomp++;
      if (get_valid(i) !== 1'b1 || get_data(i) !== data) begin
        nfail++;
        $display("FAIL result_hold: valid=%0b data=%0d, required valid=1 data=%0d", get_valid(i), get_data(i), data);
      end
    end
    res_ready_v[i] = 1'b1;
    @(posedge clk); #1;
    res_ready_v[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      ncomp++;
      if ({get_ready(i), get_valid(i), get_busy(i), get_ovf(i), get_mul(i), get_data(i)} !== 39'd0) begin
        nfail++;
        $display("FAIL reset_outputs[%0d]: rdy=%0b vld=%0b busy=%0b ovf=%0b mul=%h data=%0d, required all 0",
                 i, get_ready(i), get_valid(i), get_busy(i), get_ovf(i), get_mul(i), get_data(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_job(input string name, input int i, input int len, input logic [18:0] d, input logic o,
                           input int cyc, input int hs, input bit got, input bit timed);
    logic [18:0] es;
    logic        eo;
    model(i, len, es, eo);
    ncomp++;
    if (got !== 1'b1) begin
      nfail++;
      $display("FAIL %s_timeout: no res_valid within bound, required a result", name);
    end
    ncomp++;
    if (d !== es || o !== eo) begin
      nfail++;
      $display("FAIL %s_result: data=%0d ovf=%0b, required data=%0d ovf=%0b", name, d, o, es, eo);
    end
    ncomp++;
    if (hs !== terms(len)) begin
      nfail++;
      $display("FAIL %s_handshakes: got %0d, required %0d", name, hs, terms(len));
    end
    if (timed) begin
      ncomp++;
      if (cyc !== exp_cycles(i, len)) begin
        nfail++;
        $display("FAIL %s_latency: res_valid after %0d cycles, required %0d", name, cyc, exp_cycles(i, len));
      end
    end
    ncomp++;
    if (get_valid(i) !== 1'b0 || get_busy(i) !== 1'b0) begin
      nfail++;
      $display("FAIL %s_release: valid=%0b busy=%0b after accept, required 0 0", name, get_valid(i), get_busy(i));
    end
  endtask

  task automatic test_basic();
    logic [18:0] d; logic o; int cyc, hs; bit sr, got;
    pa[0] = 255; pb[0] = 255; pa[1] = 1; pb[1] = 1; pa[2] = 0; pb[2] = 200;
    run_job(0, 3, 0, 0, -1, d, o, cyc, hs, sr, got);
    check_job("basic", 0, 3, d, o, cyc, hs, got, 1);
    ncomp++;
    if (d !== 19'd65026) begin
      nfail++;
      $display("FAIL basic_value: data=%0d, required 65026", d);
    end
    ncomp++;
    if (get_mul(0) !== {8'd0, 8'd200}) begin
      nfail++;
      $display("FAIL basic_mul_hold: mul_a/b=%h, required 00c8", get_mul(0));
    end
    for (int r = 0; r < 4; r++) begin
      int len = int'($urandom_range(1, 8));
      fill_random();
      run_job(0, len, 0, 0, -1, d, o, cyc, hs, sr, got);
      check_job("basic_rand", 0, len, d, o, cyc, hs, got, 1);
    end
  endtask

  task automatic test_zero_len();
    logic [18:0] d; logic o; int cyc, hs; bit sr, got;
    run_job(0, 0, 0, 0, -1, d, o, cyc, hs, sr, got);
    check_job("zero_len", 0, 0, d, o, cyc, hs, got, 1);
    ncomp++;
    if (sr !== 1'b0) begin
      nfail++;
      $display("FAIL zero_len_ready: in_ready seen=%0b, required 0", sr);
    end
  endtask

  task automatic test_overflow();
    logic [18:0] d; logic o; int cyc, hs; bit sr, got;
    for (int k = 0; k < 3; k++) begin pa[k] = 255; pb[k] = 255; end
    run_job(1, 3, 0, 0, -1, d, o, cyc, hs, sr, got);
    check_job("overflow", 1, 3, d, o, cyc, hs, got, 1);
    ncomp++;
    if (d !== 19'd64003 || o !== 1'b1) begin
      nfail++;
      $display("FAIL overflow_value: data=%0d ovf=%0b, required 64003 1", d, o);
    end
    pa[0] = 1; pb[0] = 1;
    run_job(1, 1, 0, 0, -1, d, o, cyc, hs, sr, got);
    check_job("overflow_clear", 1, 1, d, o, cyc, hs, got, 1);
    for (int r = 0; r < 3; r++) begin
      int len = int'($urandom_range(1, 8));
      fill_random();
      run_job(1, len, 0, 0, -1, d, o, cyc, hs, sr, got);
      check_job("overflow_rand", 1, len, d, o, cyc, hs, got, 1);
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] d1, d2; logic o1, o2; int c1, c2, h1, h2; bit sr, g1, g2;
    fill_random();
    run_job(0, 6, 0, 0, -1, d1, o1, c1, h1, sr, g1);
    check_job("bp_nostall", 0, 6, d1, o1, c1, h1, g1, 1);
    run_job(0, 6, 3, 5, -1, d2, o2, c2, h2, sr, g2);
    check_job("bp_stall", 0, 6, d2, o2, c2, h2, g2, 0);
    ncomp++;
    if (d2 !== d1 || c2 <= c1) begin
      nfail++;
      $display("FAIL bp_compare: stall data=%0d cycles=%0d, required data=%0d cycles>%0d", d2, c2, d1, c1);
    end
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      ncomp++;
      if (rv0 !== 1'b0) begin
        nfail++;
        $display("FAIL bp_single_result: res_valid=%0b after accept, required 0", rv0);
      end
    end
  endtask

  task automatic test_abort_reset();
    logic [18:0] d; logic o; int cyc, hs; bit sr, got;
    fill_random();
    run_job(0, 4, 0, 0, 2, d, o, cyc, hs, sr, got);
    ncomp++;
    if (got !== 1'b0 || hs !== 2 || bz0 !== 1'b0) begin
      nfail++;
      $display("FAIL abort_idle: got=%0b hs=%0d busy=%0b, required 0 2 0", got, hs, bz0);
    end
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      ncomp++;
      if (rv0 !== 1'b0 || bz0 !== 1'b0) begin
        nfail++;
        $display("FAIL abort_quiet: valid=%0b busy=%0b, required 0 0", rv0, bz0);
      end
    end
    fill_random();
    run_job(0, 2, 0, 0, -1, d, o, cyc, hs, sr, got);
    check_job("after_abort", 0, 2, d, o, cyc, hs, got, 1);

    pa[0] = int'($urandom_range(1, 255)); pb[0] = int'($urandom_range(1, 255));
    @(negedge clk);
    start_v[0] = 1'b1; len_v[0] = 4'd2;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    in_valid_v[0] = 1'b1; in_a_v[0] = 8'(pa[0]); in_b_v[0] = 8'(pb[0]);
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    ncomp++;
    if (ir0 !== 1'b1 || {ma0, mb0} !== {8'(pa[0]), 8'(pb[0])}) begin
      nfail++;
      $display("FAIL reset_setup: in_ready=%0b mul=%h, required 1 %02h%02h", ir0, {ma0, mb0}, pa[0], pb[0]);
    end
    rst_n = 1'b0;
    #1;
    ncomp++;
    if ({ir0, rv0, bz0, ov0, ma0, mb0, rd0} !== 39'd0) begin
      nfail++;
      $display("FAIL reset_midjob: rdy=%0b vld=%0b busy=%0b ovf=%0b mul=%h data=%0d, required all 0",
               ir0, rv0, bz0, ov0, {ma0, mb0}, rd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    run_job(0, 3, 0, 0, -1, d, o, cyc, hs, sr, got);
    check_job("after_reset", 0, 3, d, o, cyc, hs, got, 1);
  endtask

  task automatic test_clamp_latency();
    logic [18:0] d; logic o; int cyc, hs; bit sr, got;
    fill_random();
    run_job(0, 15, 0, 0, -1, d, o, cyc, hs, sr, got);
    check_job("clamp", 0, 15, d, o, cyc, hs, got, 1);
    for (int r = 0; r < 3; r++) begin
      fill_random();
      for (int k = 0; k < 16; k++) begin
        pa[k] = int'($urandom_range(1, 255));
        pb[k] = (k == 0) ? int'($urandom_range(1, 255)) : pb[k-1] % 255 + 1;
      end
      run_job(2, (r == 2) ? 15 : r + 2, 0, 0, -1, d, o, cyc, hs, sr, got);
      check_job("lat3", 2, (r == 2) ? 15 : r + 2, d, o, cyc, hs, got, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start_v = '0; abort_v = '0; in_valid_v = '0; res_ready_v = '0;
    len_v = '0; in_a_v = '0; in_b_v = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_backpressure();
    test_abort_reset();
    test_clamp_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
